// File: rtl/boid_draw_scheduler_if.sv
// Position-RAM read port and framebuffer write-request port of the boid draw scheduler.
// master = scheduler side; slave = position RAM / framebuffer arbiter side.
interface boid_draw_scheduler_if #(
  parameter int unsigned IDX_W                 = 4,
  parameter int unsigned PIXEL_ADDRESS_WIDTH   = 20,
  parameter int unsigned PALETTE_ADDRESS_WIDTH = 9
);

  logic [IDX_W-1:0]                 pos_idx;
  logic [9:0]                       pos_x;
  logic [8:0]                       pos_y;
  logic                             fb_req;
  logic                             fb_grant;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   fb_addr;
  logic [PALETTE_ADDRESS_WIDTH-1:0] fb_data;

  modport master (
    output pos_idx,
    input  pos_x,
    input  pos_y,
    output fb_req,
    input  fb_grant,
    output fb_addr,
    output fb_data
  );

  modport slave (
    input  pos_idx,
    output pos_x,
    output pos_y,
    input  fb_req,
    output fb_grant,
    input  fb_addr,
    input  fb_data
  );

endinterface

// File: rtl/boid_draw_scheduler.sv
// Per-frame boid sequencer: for every slot, read its position, erase the previously
// drawn pixel and draw the new one through the shared framebuffer write port.
module boid_draw_scheduler #(
  parameter int unsigned NUM_BOIDS             = 16,
  parameter int unsigned PIXEL_ADDRESS_WIDTH   = 20,
  parameter int unsigned PALETTE_ADDRESS_WIDTH = 9,
  parameter logic [PALETTE_ADDRESS_WIDTH-1:0] BG_COLOR   = 9'd0,
  parameter logic [PALETTE_ADDRESS_WIDTH-1:0] BOID_COLOR = 9'd255
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_start,
  boid_draw_scheduler_if.master  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_BOIDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [9:0]                       x_q, x_d;
  logic [8:0]                       y_q, y_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   new_addr_q, new_addr_d;
  logic                             new_valid_q, new_valid_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   old_addr_q [NUM_BOIDS];
  logic [PIXEL_ADDRESS_WIDTH-1:0]   old_addr_d [NUM_BOIDS];
  logic [NUM_BOIDS-1:0]             old_valid_q, old_valid_d;
  logic [IDX_W-1:0]                 pos_idx_q, pos_idx_d;
  logic                             fb_req_q, fb_req_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   fb_addr_q, fb_addr_d;
  logic [PALETTE_ADDRESS_WIDTH-1:0] fb_data_q, fb_data_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             overrun_q, overrun_d;

  logic [PIXEL_ADDRESS_WIDTH-1:0]   x_ext, y_ext, calc_addr;
  logic                             calc_valid;
  logic                             advance;

  // 640-wide row stride as (y<<9)+(y<<7), all at full address width.
  always_comb begin
    x_ext      = PIXEL_ADDRESS_WIDTH'(x_q);
    y_ext      = PIXEL_ADDRESS_WIDTH'(y_q);
    calc_addr  = x_ext + (y_ext << 9) + (y_ext << 7);
    calc_valid = (x_q < 10'd640) && (y_q < 9'd480);
  end

  // Outputs are registered, so each transition loads the values the next state presents.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    new_addr_d  = new_addr_q;
    new_valid_d = new_valid_q;
    old_addr_d  = old_addr_q;
    old_valid_d = old_valid_q;
    pos_idx_d   = pos_idx_q;
    fb_req_d    = fb_req_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    advance     = 1'b0;

    if (frame_start && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          busy_d    = 1'b1;
          idx_d     = '0;
          pos_idx_d = '0;
          state_d   = S_READ;
        end
      end

      S_READ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        x_d     = bus.pos_x;
        y_d     = bus.pos_y;
        state_d = S_CALC;
      end

      S_CALC: begin
        new_addr_d  = calc_addr;
        new_valid_d = calc_valid;
        state_d     = S_ERASE;
        if (old_valid_q[idx_q]) begin
          fb_req_d  = 1'b1;
          fb_addr_d = old_addr_q[idx_q];
          fb_data_d = BG_COLOR;
        end
      end

      S_ERASE: begin
        if (!fb_req_q || bus.fb_grant) begin
          state_d  = S_DRAW;
          fb_req_d = new_valid_q;
          if (new_valid_q) begin
            fb_addr_d = new_addr_q;
            fb_data_d = BOID_COLOR;
          end
        end
      end

      S_DRAW: begin
        advance = !fb_req_q || bus.fb_grant;
        if (advance) begin
          fb_req_d           = 1'b0;
          old_valid_d[idx_q] = new_valid_q;
          if (new_valid_q) begin
            old_addr_d[idx_q] = new_addr_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            pos_idx_d = idx_q + IDX_W'(1);
            state_d   = S_READ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      new_addr_q  <= '0;
      new_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BOIDS; i++) begin
        old_addr_q[i] <= '0;
      end
      old_valid_q <= '0;
      pos_idx_q   <= '0;
      fb_req_q    <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      new_addr_q  <= new_addr_d;
      new_valid_q <= new_valid_d;
      old_addr_q  <= old_addr_d;
      old_valid_q <= old_valid_d;
      pos_idx_q   <= pos_idx_d;
      fb_req_q    <= fb_req_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pos_idx = pos_idx_q;
  assign bus.fb_req  = fb_req_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_boid_draw_scheduler.sv
// Directed-plus-random bench for boid_draw_scheduler against a per-frame write-list model.
module tb_boid_draw_scheduler;

  localparam int N = 16;

  logic clock = 1'b0;
  logic resetn;
  logic frame_start;
  logic busy, done, overrun;

  boid_draw_scheduler_if #(.IDX_W(4), .PIXEL_ADDRESS_WIDTH(20), .PALETTE_ADDRESS_WIDTH(9)) bus ();

  boid_draw_scheduler #(
    .NUM_BOIDS(16),
    .PIXEL_ADDRESS_WIDTH(20),
    .PALETTE_ADDRESS_WIDTH(9),
    .BG_COLOR(9'd0),
    .BOID_COLOR(9'd255)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_start(frame_start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Position RAM: one-cycle read latency.
  logic [9:0] ram_x [N];
  logic [8:0] ram_y [N];
  always @(posedge clock) begin
    bus.pos_x <= ram_x[bus.pos_idx];
    bus.pos_y <= ram_y[bus.pos_idx];
  end

  typedef struct {
    logic [19:0] addr;
    logic [8:0]  data;
    int          edge_t;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  bit  mdl_v [N];
  int  mdl_a [N];
  int  errors = 0;
  int  checks = 0;
  int  E = 0;

  // Record every committed write with the clock edge it commits on.
  always @(negedge clock) begin
    wr_t w;
    #1;
    if (resetn === 1'b1 && bus.fb_req === 1'b1 && bus.fb_grant === 1'b1) begin
      w.addr   = bus.fb_addr;
      w.data   = bus.fb_data;
      w.edge_t = cyc + 1;
      got_q.push_back(w);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_idx"}, 32'(bus.pos_idx), 0);
    check({tag, "_fb_req"},  32'(bus.fb_req), 0);
    check({tag, "_fb_addr"}, 32'(bus.fb_addr), 0);
    check({tag, "_fb_data"}, 32'(bus.fb_data), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  // Reference: per slot, erase the remembered pixel (if any) then draw the new one if on screen.
  function automatic void build_exp();
    wr_t w;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int x = int'(ram_x[i]);
      int y = int'(ram_y[i]);
      bit v = (x < 640) && (y < 480);
      if (mdl_v[i]) begin
        w.addr = 20'(mdl_a[i]); w.data = 9'd0; w.edge_t = 5 * i + 4;
        exp_q.push_back(w);
      end
      if (v) begin
        w.addr = 20'(x + 640 * y); w.data = 9'd255; w.edge_t = 5 * i + 5;
        exp_q.push_back(w);
        mdl_v[i] = 1'b1;
        mdl_a[i] = x + 640 * y;
      end else begin
        mdl_v[i] = 1'b0;
      end
    end
  endfunction

  task automatic randomize_positions();
    for (int i = 0; i < N; i++) begin
      ram_x[i] = 10'($urandom_range(0, 700));
      ram_y[i] = 9'($urandom_range(0, 511));
    end
  endtask

  task automatic start_frame();
    got_q.delete();
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    E = cyc;
  endtask

  task automatic wait_done(input int early_at, input int reset_at, input bit bp, input bit rnd,
                           input int exp_len, input logic [19:0] bp_addr);
    bit seen = 1'b0;
    int rel  = 0;
    check("busy_in_frame", 32'(busy), 1);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      rel = cyc - E;
      frame_start = (rel == early_at - 1);
      if (rnd) bus.fb_grant = 1'($urandom_range(0, 1));
      if (bp) begin
        if (rel >= 3 && rel <= 6) begin
          check("bp_req",  32'(bus.fb_req), 1);
          check("bp_addr", 32'(bus.fb_addr), 32'(bp_addr));
          check("bp_data", 32'(bus.fb_data), 0);
        end
        bus.fb_grant = !(rel >= 3 && rel <= 5);
      end
      if (rel == reset_at) begin
        resetn = 1'b0;
        frame_start = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        resetn = 1'b1;
        bus.fb_grant = 1'b1;
        return;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    frame_start  = 1'b0;
    bus.fb_grant = 1'b1;
    check("done_seen", 32'(seen), 1);
    if (seen) begin
      check("busy_at_done", 32'(busy), 0);
      if (exp_len >= 0) check("done_time", 32'(rel), 32'(exp_len));
      @(negedge clock);
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  task automatic check_frame(input string tag, input bit timed);
    int n;
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check({tag, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
      if (timed) check({tag, "_edge"}, 32'(got_q[i].edge_t - E), 32'(exp_q[i].edge_t));
    end
  endtask

  initial begin
    logic [19:0] bp_addr;
    resetn       = 1'b0;
    frame_start  = 1'b0;
    bus.fb_grant = 1'b1;
    for (int i = 0; i < N; i++) begin
      ram_x[i] = 10'(10 + i);
      ram_y[i] = 9'd10;
      mdl_v[i] = 1'b0;
      mdl_a[i] = 0;
    end
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    resetn = 1'b1;
    @(negedge clock);
    check_reset_values("post_reset");

    // Initial frame: draws only.
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b0, 80, '0);
    check_frame("frame1", 1'b1);

    // Every boid moves right by one.
    for (int i = 0; i < N; i++) ram_x[i] = 10'(11 + i);
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b0, 80, '0);
    check_frame("moved", 1'b1);

    // Grant withheld for three cycles during slot 0's erase.
    bp_addr = 20'(mdl_a[0]);
    for (int i = 0; i < N; i++) ram_x[i] = 10'(12 + i);
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b1, 1'b0, 83, bp_addr);
    check_frame("backpressure", 1'b0);

    // Screen corners and off-screen slot.
    randomize_positions();
    ram_x[0] = 10'd639; ram_y[0] = 9'd479;
    ram_x[1] = 10'd640; ram_y[1] = 9'd0;
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b0, 80, '0);
    check_frame("boundary", 1'b1);
    check("corner_addr", 32'(got_q.size() > 1 ? got_q[1].addr : 20'd0), 32'd307199);

    randomize_positions();
    ram_x[1] = 10'd0; ram_y[1] = 9'd0;
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b0, 80, '0);
    check_frame("after_offscreen", 1'b1);
    check("overrun_clear", 32'(overrun), 0);

    // frame_start while busy.
    randomize_positions();
    build_exp();
    start_frame();
    wait_done(20, -1, 1'b0, 1'b0, 80, '0);
    check_frame("early_start", 1'b1);
    check("overrun_set", 32'(overrun), 1);

    // Random back-pressure.
    randomize_positions();
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b1, -1, '0);
    check_frame("rand_grant", 1'b0);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset in the middle of a frame forgets every remembered pixel.
    randomize_positions();
    build_exp();
    start_frame();
    wait_done(-1, 40, 1'b0, 1'b0, -1, '0);
    for (int i = 0; i < N; i++) mdl_v[i] = 1'b0;
    @(negedge clock);
    build_exp();
    start_frame();
    wait_done(-1, -1, 1'b0, 1'b0, 80, '0);
    check_frame("after_reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
